// File: rtl/spi_flash_rd_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_flash_rd_responder
// Description : Read-only memory-bus responder for the flash window
//               (mem_addr[23]=1). Each accepted strobe issues one SPI READ
//               (0x03) and returns one little-endian 32-bit word.
//               SPI mode 0, MSB first. The latest strobe always wins.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_rd_responder #(
    parameter int HALF_PERIOD = 1,  // clk cycles per SCLK half-period (>=1)
    parameter int CS_GAP      = 2   // min clk cycles with spi_cs_n high between transfers (>=1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_rbusy,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int c_half_w = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int c_gap_w  = $clog2(CS_GAP + 1);

    localparam logic [c_half_w-1:0] c_half_last = c_half_w'(HALF_PERIOD - 1);
    localparam logic [c_gap_w-1:0]  c_gap_load  = c_gap_w'(CS_GAP);
    localparam logic [7:0]          c_cmd_read  = 8'h03;
    localparam logic [5:0]          c_bit_last  = 6'd63;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [23:0]         r_flash_addr;
    logic                r_pending;
    logic [5:0]          r_bit_cnt;
    logic [c_half_w-1:0] r_half_cnt;
    logic [c_gap_w-1:0]  r_gap_cnt;
    logic [31:0]         r_tx;
    logic [31:0]         r_rx;
    logic                r_cs_n;
    logic                r_sclk;
    logic                r_mosi;
    logic                r_rbusy;
    logic [31:0]         r_rdata;
    logic                w_cs_n_nxt;
    logic                w_sclk_nxt;
    logic                w_mosi_nxt;

    logic        w_accept;
    logic        w_busy;
    logic        w_half_end;
    logic        w_bit_end;
    logic        w_xfer_end;
    logic        w_start;
    logic [31:0] w_cmd;
    logic        w_unused_addr;

    // Only the flash window is ours; the rest of the map belongs to on-chip RAM.
    assign w_accept   = mem_rstrb & mem_addr[23];
    assign w_busy     = (r_state == c_st_shift) | r_pending;
    assign w_half_end = (r_half_cnt == c_half_last);
    assign w_bit_end  = (r_bit_cnt == c_bit_last);
    // Last high phase of the 64th bit: the word is complete on this edge.
    assign w_xfer_end = (r_state == c_st_shift) & r_sclk & w_half_end & w_bit_end;
    assign w_start    = (r_state == c_st_idle) & (w_state_nxt == c_st_shift);
    assign w_cmd      = {c_cmd_read, r_flash_addr};

    // Word reads are always aligned, and bits above 23 are decoded elsewhere.
    assign w_unused_addr = ^{mem_addr[31:24], mem_addr[1:0]};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a new strobe always restarts the request handling.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (!w_accept && r_pending && (r_gap_cnt == '0)) begin
                    w_state_nxt = c_st_shift;
                end
            end
            c_st_shift: begin
                if (w_xfer_end) begin
                    w_state_nxt = c_st_done;
                end else if (w_accept) begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Next values of the SPI pins; MOSI changes only at SHIFT entry or SCLK fall.
    always_comb begin
        w_cs_n_nxt = r_cs_n;
        w_sclk_nxt = r_sclk;
        w_mosi_nxt = r_mosi;
        case (r_state)
            c_st_idle: begin
                if (w_start) begin
                    w_cs_n_nxt = 1'b0;
                    w_sclk_nxt = 1'b0;
                    w_mosi_nxt = w_cmd[31];
                end else begin
                    w_cs_n_nxt = 1'b1;
                    w_sclk_nxt = 1'b0;
                    w_mosi_nxt = 1'b0;
                end
            end
            c_st_shift: begin
                if (w_xfer_end || w_accept) begin
                    w_cs_n_nxt = 1'b1;
                    w_sclk_nxt = 1'b0;
                    w_mosi_nxt = 1'b0;
                end else if (w_half_end) begin
                    w_sclk_nxt = ~r_sclk;
                    if (r_sclk) begin
                        w_mosi_nxt = r_tx[31];
                    end
                end
            end
            default: begin
                w_cs_n_nxt = 1'b1;
                w_sclk_nxt = 1'b0;
                w_mosi_nxt = 1'b0;
            end
        endcase
    end

    // Pins, request capture, busy flag, CS gap counter and the returned word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_n       <= 1'b1;
            r_sclk       <= 1'b0;
            r_mosi       <= 1'b0;
            r_rbusy      <= 1'b0;
            r_rdata      <= '0;
            r_pending    <= 1'b0;
            r_flash_addr <= '0;
            r_gap_cnt    <= '0;
        end else begin
            r_cs_n <= w_cs_n_nxt;
            r_sclk <= w_sclk_nxt;
            r_mosi <= w_mosi_nxt;

            if (w_accept) begin
                r_flash_addr <= {1'b0, mem_addr[22:2], 2'b00};
                r_pending    <= 1'b1;
            end else if (w_start) begin
                r_pending <= 1'b0;
            end

            if (w_accept) begin
                r_rbusy <= 1'b1;
            end else if (w_xfer_end) begin
                r_rbusy <= 1'b0;
            end

            // A strobe that interrupts work, or a completed transfer, reopens the gap.
            if ((w_accept && w_busy) || w_xfer_end) begin
                r_gap_cnt <= c_gap_load;
            end else if (r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - c_gap_w'(1);
            end

            // Data bytes arrive MSB first, byte0 ends up in r_rx[31:24].
            if (w_xfer_end) begin
                r_rdata <= {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
            end
        end
    end

    // Shift engine: half-period timing, bit count, command shift-out, MISO capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_half_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
        end else if (w_start) begin
            r_half_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= {w_cmd[30:0], 1'b0};
        end else if (r_state == c_st_shift) begin
            if (!w_half_end) begin
                r_half_cnt <= r_half_cnt + c_half_w'(1);
            end else begin
                r_half_cnt <= '0;
                if (!r_sclk) begin
                    r_rx <= {r_rx[30:0], spi_miso};
                end else if (!w_bit_end) begin
                    r_bit_cnt <= r_bit_cnt + 6'd1;
                    r_tx      <= {r_tx[30:0], 1'b0};
                end
            end
        end
    end

    assign mem_rdata = r_rdata;
    assign mem_rbusy = r_rbusy;
    assign spi_cs_n  = r_cs_n;
    assign spi_sclk  = r_sclk;
    assign spi_mosi  = r_mosi;

endmodule
`default_nettype wire
